// File: rtl/mem_load_pkg.sv
// Shared types and helpers for the stream-to-memory writer.
package mem_load_pkg;

    // Writer FSM encoding, same 2-bit layout as the block-copy engine.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_FLUSH = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    // Ceiling log2, never below 1 so address buses keep a legal width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((33'd1 << i) < 33'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_load.sv
// Stream-to-memory writer: accepts a valid/ready stream and writes consecutive
// words into [start, end] (wrapping modulo 2^AW), then pulses o_done.
// Optional build macro MEM_LOAD_ABORT_EN adds i_abort to end a load early.
module mem_load
    import mem_load_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned MAX_MEM_DEPTH = 16,
    localparam int unsigned AW           = clog2(MAX_MEM_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [AW-1:0]    i_start_addr,
    input  logic [AW-1:0]    i_end_addr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
`ifdef MEM_LOAD_ABORT_EN
    input  logic             i_abort,
`endif
    output logic             o_ready,
    output logic [AW-1:0]    o_mem_addr,
    output logic             o_mem_en,
    output logic [WIDTH-1:0] o_mem_data,
    output logic             o_done
);

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    end_q, end_d;
    logic [AW-1:0]    mem_addr_d;
    logic [WIDTH-1:0] mem_data_d;
    logic             mem_en_d;
    logic             done_d;
    logic             xfer_c;
    logic             abort_c;

    // Stream handshake: ready only while loading.
    assign o_ready = (state_q == S_LOAD);
    assign xfer_c  = i_valid && o_ready;

`ifdef MEM_LOAD_ABORT_EN
    assign abort_c = i_abort;
`else
    assign abort_c = 1'b0;
`endif

    // State, address counter and registered memory-port outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            end_q      <= '0;
            o_mem_addr <= '0;
            o_mem_en   <= 1'b0;
            o_mem_data <= '0;
            o_done     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            o_mem_addr <= mem_addr_d;
            o_mem_en   <= mem_en_d;
            o_mem_data <= mem_data_d;
            o_done     <= done_d;
        end
    end

    // Next-state and next-output decode; address/data hold unless written.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        end_d      = end_q;
        mem_addr_d = o_mem_addr;
        mem_data_d = o_mem_data;
        mem_en_d   = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = i_start_addr;
                    end_d   = i_end_addr;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer_c) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = i_data;
                    addr_d     = addr_q + AW'(1);
                    if (addr_q == end_q) state_d = S_FLUSH;
                end
                if (abort_c) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_load.sv
// Self-checking bench for mem_load: transaction-level model plus per-cycle compare.
module tb_mem_load;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start;
    logic [AW-1:0]    i_start_addr;
    logic [AW-1:0]    i_end_addr;
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic             i_abort;
    logic             o_ready;
    logic [AW-1:0]    o_mem_addr;
    logic             o_mem_en;
    logic [WIDTH-1:0] o_mem_data;
    logic             o_done;

    mem_load #(.WIDTH(WIDTH), .MAX_MEM_DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_start_addr (i_start_addr),
        .i_end_addr   (i_end_addr),
        .i_data       (i_data),
        .i_valid      (i_valid),
`ifdef MEM_LOAD_ABORT_EN
        .i_abort      (i_abort),
`endif
        .o_ready      (o_ready),
        .o_mem_addr   (o_mem_addr),
        .o_mem_en     (o_mem_en),
        .o_mem_data   (o_mem_data),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef enum int {M_IDLE, M_LOAD, M_TAIL} mphase_t;
    mphase_t     phase         = M_IDLE;
    int          m_cur         = 0;
    int          m_left        = 0;
    int          m_tail        = 0;
    int          mcyc          = 0;
    int          xfer_count    = 0;
    int          last_xfer_cyc = 0;
    logic        exp_en        = 1'b0;
    logic        exp_done      = 1'b0;
    int          exp_addr      = 0;
    logic [31:0] exp_data      = '0;
    logic        m_abort;

`ifdef MEM_LOAD_ABORT_EN
    assign m_abort = i_abort;
`else
    assign m_abort = 1'b0;
`endif

    // Words are consumed from a count derived from the range; the write for a
    // transfer shows up the next cycle, done one cycle after that, then idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    = M_IDLE;
            exp_en   = 1'b0;
            exp_done = 1'b0;
            exp_addr = 0;
            exp_data = '0;
        end else begin
            exp_en   = 1'b0;
            exp_done = 1'b0;
            case (phase)
                M_IDLE: if (i_start) begin
                    m_cur  = int'(i_start_addr);
                    m_left = ((int'(i_end_addr) - int'(i_start_addr) + DEPTH) % DEPTH) + 1;
                    phase  = M_LOAD;
                end
                M_LOAD: begin
                    if (i_valid) begin
                        exp_en        = 1'b1;
                        exp_addr      = m_cur;
                        exp_data      = i_data;
                        m_cur         = (m_cur + 1) % DEPTH;
                        m_left        = m_left - 1;
                        xfer_count    = xfer_count + 1;
                        last_xfer_cyc = mcyc;
                    end
                    if (m_left == 0 || m_abort) begin
                        phase  = M_TAIL;
                        m_tail = 0;
                    end
                end
                default: begin
                    m_tail = m_tail + 1;
                    if (m_tail == 1) exp_done = 1'b1;
                    if (m_tail == 2) phase = M_IDLE;
                end
            endcase
            mcyc = mcyc + 1;
        end
    end

    // Per-cycle compare of DUT outputs against the model, plus write capture.
    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];
    int            obs_done = 0;
    int            done_cyc = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ready", 32'(o_ready), 32'(phase == M_LOAD));
            chk("mem_en", 32'(o_mem_en), 32'(exp_en));
            chk("done", 32'(o_done), 32'(exp_done));
            chk("mem_data", o_mem_data, exp_data);
            if (exp_en) chk("mem_addr", 32'(o_mem_addr), 32'(exp_addr));
            if (o_mem_en) begin
                obs_addr.push_back(o_mem_addr);
                obs_data.push_back(o_mem_data);
            end
            if (o_done) begin
                obs_done = obs_done + 1;
                done_cyc = mcyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    int ea[8];

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_done = 0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (phase != M_IDLE && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (phase != M_IDLE) chk("idle_timeout", 32'(g), 32'(0));
    endtask

    // Called at posedge+1 with the block idle; runs one load to completion.
    task automatic run_load(input int s, input int e, input logic [31:0] base,
                            input bit rnd_data, input int vpct,
                            input logic [15:0] vpat, input int vpat_len, input int abort_at);
        int x0, k, pidx, guard;
        i_start      = 1'b1;
        i_start_addr = AW'(s);
        i_end_addr   = AW'(e);
        @(posedge clk); #1;
        i_start = 1'b0;
        x0      = xfer_count;
        pidx    = 0;
        guard   = 0;
        while (phase == M_LOAD && guard < 500) begin
            k = xfer_count - x0;
            if (pidx < vpat_len) i_valid = vpat[pidx];
            else                 i_valid = (int'($urandom_range(99)) < vpct);
            pidx++;
            i_data       = rnd_data ? $urandom : base + 32'(k);
            i_start_addr = AW'($urandom);
            i_end_addr   = AW'($urandom);
            i_start      = (k == 1) || ($urandom_range(3) == 0);
            i_abort      = (abort_at > 0) && (k == abort_at - 1) && i_valid;
            @(posedge clk); #1;
            guard++;
        end
        i_valid = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        if (phase == M_LOAD) chk("load_timeout", 32'(guard), 32'(0));
        wait_idle();
    endtask

    task automatic check_seq(input string tag, input int n, input logic [31:0] base);
        chk({tag, "_count"}, 32'(obs_addr.size()), 32'(n));
        for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            chk({tag, "_addr"}, 32'(obs_addr[i]), 32'(ea[i]));
            chk({tag, "_data"}, obs_data[i], base + 32'(i));
        end
        chk({tag, "_done_cnt"}, 32'(obs_done), 32'(1));
        chk({tag, "_done_lat"}, 32'(done_cyc - last_xfer_cyc), 32'(2));
    endtask

    initial begin
        int x0, g, d0;
        rst_n = 1'b1; i_start = 1'b0; i_start_addr = '0; i_end_addr = '0;
        i_data = '0; i_valid = 1'b0; i_abort = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", 32'(o_mem_en), 32'(0));
        chk("rst_addr", 32'(o_mem_addr), 32'(0));
        chk("rst_data", o_mem_data, 32'(0));
        chk("rst_done", 32'(o_done), 32'(0));
        chk("rst_ready", 32'(o_ready), 32'(0));
        rst_n  = 1'b1;
        chk_on = 1'b1;
        @(posedge clk); #1;

        // Basic range, valid held high.
        clear_obs(); ea = '{2, 3, 4, 5, 0, 0, 0, 0};
        run_load(2, 5, 32'hA0, 1'b0, 100, 16'h0, 0, 0);
        check_seq("basic", 4, 32'hA0);

        // Single word.
        clear_obs(); ea = '{7, 0, 0, 0, 0, 0, 0, 0};
        run_load(7, 7, 32'hDEAD, 1'b0, 100, 16'h0, 0, 0);
        check_seq("single", 1, 32'hDEAD);

        // Wrap past the top of memory.
        clear_obs(); ea = '{14, 15, 0, 1, 0, 0, 0, 0};
        run_load(14, 1, 32'h100, 1'b0, 100, 16'h0, 0, 0);
        check_seq("wrap", 4, 32'h100);

        // Bubbles: valid pattern 1,0,0,1,1,0,1.
        clear_obs(); ea = '{0, 1, 2, 3, 0, 0, 0, 0};
        run_load(0, 3, 32'h200, 1'b0, 100, 16'b1011001, 7, 0);
        check_seq("bubble", 4, 32'h200);

        // Reset mid-load after 2 of 6 words.
        i_start = 1'b1; i_start_addr = AW'(0); i_end_addr = AW'(5);
        @(posedge clk); #1;
        i_start = 1'b0;
        x0 = xfer_count; g = 0;
        while (xfer_count - x0 < 2 && g < 20) begin
            i_valid = 1'b1;
            i_data  = 32'hB0 + 32'(xfer_count - x0);
            @(posedge clk); #1;
            g++;
        end
        i_valid = 1'b0;
        chk("midrst_inflight", 32'(o_mem_en), 32'(1));
        d0 = obs_done;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en", 32'(o_mem_en), 32'(0));
        chk("midrst_ready", 32'(o_ready), 32'(0));
        chk("midrst_done", 32'(o_done), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(obs_done), 32'(d0));
        clear_obs(); ea = '{3, 4, 0, 0, 0, 0, 0, 0};
        run_load(3, 4, 32'hC0, 1'b0, 100, 16'h0, 0, 0);
        check_seq("recover", 2, 32'hC0);

`ifdef MEM_LOAD_ABORT_EN
        // Abort alongside the 3rd transfer.
        clear_obs(); ea = '{0, 1, 2, 0, 0, 0, 0, 0};
        run_load(0, 9, 32'hE0, 1'b0, 100, 16'h0, 0, 3);
        check_seq("abort", 3, 32'hE0);
`endif

        // Randomized loads checked cycle by cycle against the model.
        for (int t = 0; t < 25; t++) begin
            int ab;
            ab = 0;
`ifdef MEM_LOAD_ABORT_EN
            if ($urandom_range(3) == 0) ab = int'($urandom_range(1, 6));
`endif
            repeat ($urandom_range(2)) @(posedge clk);
            #0;
            run_load(int'($urandom_range(15)), int'($urandom_range(15)), 32'h0, 1'b1,
                     int'($urandom_range(30, 100)), 16'h0, 0, ab);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
